// File: rtl/toaplan2_gfx_arb.sv
// GP9001 graphics fetch arbiter: four 32-bit slots with one-entry caches
// sharing one SDRAM read port. Define TOAPLAN2_GFX_ARB_PRIO0_EN for sprite priority.
module toaplan2_gfx_arb #(
  parameter int SDRAMW = 22,
  parameter int unsigned OFFSET = 0
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  FLUSH,
  input  logic [3:0]            SLOT_CS,
  input  logic [4*SDRAMW-1:0]   SLOT_ADDR,
  output logic [3:0]            SLOT_OK,
  output logic [127:0]          SLOT_DOUT,
  output logic [SDRAMW-1:0]     SDRAM_ADDR,
  output logic                  SDRAM_REQ,
  input  logic                  SDRAM_ACK,
  input  logic                  DATA_DST,
  input  logic                  DATA_RDY,
  input  logic [15:0]           DATA_READ
);

  localparam logic [SDRAMW-1:0] OFF = SDRAMW'(OFFSET);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA0,
    DATA1
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        valid_q;
  logic [SDRAMW-1:0] tag_q [4];
  logic [31:0]       dout_q [4];
  logic [1:0]        ptr_q;
  logic [1:0]        gnt_q;
  logic [SDRAMW-1:0] addr_q;
  logic [15:0]       word0_q;
  logic              flush_seen_q;
  logic              req_q;
  logic [SDRAMW-1:0] sdram_addr_q;

  logic [SDRAMW-1:0] saddr [4];
  logic [3:0]        ok;
  logic [3:0]        miss;
  logic              found;
  logic [1:0]        sel;
  logic [1:0]        ptr_nxt;

`ifdef TOAPLAN2_GFX_ARB_PRIO0_EN
  function automatic logic [1:0] nxt3(input logic [1:0] p);
    return (p == 2'd3) ? 2'd1 : p + 2'd1;
  endfunction
`endif

  // Unpack slot addresses and evaluate per-slot hits
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      saddr[i] = SLOT_ADDR[i*SDRAMW +: SDRAMW];
      ok[i]    = SLOT_CS[i] & valid_q[i] & (saddr[i] == tag_q[i]);
    end
    miss = SLOT_CS & ~ok;
  end

  // Pack cached data onto the output bus
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      SLOT_DOUT[i*32 +: 32] = dout_q[i];
    end
  end

  assign SLOT_OK    = ok;
  assign SDRAM_REQ  = req_q;
  assign SDRAM_ADDR = sdram_addr_q;

  // Pick the next missing slot and the pointer value after its fill
  always_comb begin
    logic [1:0] c;
    found = 1'b0;
    sel   = 2'd0;
`ifdef TOAPLAN2_GFX_ARB_PRIO0_EN
    c = (ptr_q == 2'd0) ? 2'd1 : ptr_q;
    if (miss[0]) begin
      found = 1'b1;
      sel   = 2'd0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!found && miss[c]) begin
          found = 1'b1;
          sel   = c;
        end
        c = nxt3(c);
      end
    end
    ptr_nxt = (gnt_q == 2'd0) ? ptr_q : nxt3(gnt_q);
`else
    c = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!found && miss[c]) begin
        found = 1'b1;
        sel   = c;
      end
      c = c + 2'd1;
    end
    ptr_nxt = gnt_q + 2'd1;
`endif
  end

  // Transaction sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (found)     state_d = REQ;
      REQ:   if (SDRAM_ACK) state_d = DATA0;
      DATA0: if (DATA_DST)  state_d = DATA1;
      DATA1: if (DATA_RDY)  state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Grant latch, SDRAM request, word capture and cache fill
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid_q      <= '0;
      ptr_q        <= '0;
      gnt_q        <= '0;
      addr_q       <= '0;
      word0_q      <= '0;
      flush_seen_q <= 1'b0;
      req_q        <= 1'b0;
      sdram_addr_q <= '0;
      for (int i = 0; i < 4; i++) begin
        tag_q[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      if (FLUSH) valid_q <= '0;
      if (FLUSH && state_q != IDLE) flush_seen_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          flush_seen_q <= 1'b0;
          if (found) begin
            gnt_q        <= sel;
            addr_q       <= saddr[sel];
            sdram_addr_q <= saddr[sel] + OFF;
            req_q        <= 1'b1;
          end
        end
        REQ: begin
          if (SDRAM_ACK) req_q <= 1'b0;
        end
        DATA0: begin
          if (DATA_DST) word0_q <= DATA_READ;
        end
        DATA1: begin
          if (DATA_RDY) begin
            dout_q[gnt_q]  <= {DATA_READ, word0_q};
            tag_q[gnt_q]   <= addr_q;
            valid_q[gnt_q] <= ~(flush_seen_q | FLUSH);
            ptr_q          <= ptr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_toaplan2_gfx_arb.sv
// Directed bench for toaplan2_gfx_arb with an expected-transaction queue.
// The SDRAM side is served by hand from the queued expectations.
module tb_toaplan2_gfx_arb;

  localparam int W = 22;

  logic           CLK;
  logic           RESET_N;
  logic           FLUSH;
  logic [3:0]     SLOT_CS;
  logic [4*W-1:0] SLOT_ADDR;
  logic [3:0]     SLOT_OK;
  logic [127:0]   SLOT_DOUT;
  logic [W-1:0]   SDRAM_ADDR;
  logic           SDRAM_REQ;
  logic           SDRAM_ACK;
  logic           DATA_DST;
  logic           DATA_RDY;
  logic [15:0]    DATA_READ;

  toaplan2_gfx_arb #(.SDRAMW(W), .OFFSET(0)) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .FLUSH(FLUSH),
    .SLOT_CS(SLOT_CS),
    .SLOT_ADDR(SLOT_ADDR),
    .SLOT_OK(SLOT_OK),
    .SLOT_DOUT(SLOT_DOUT),
    .SDRAM_ADDR(SDRAM_ADDR),
    .SDRAM_REQ(SDRAM_REQ),
    .SDRAM_ACK(SDRAM_ACK),
    .DATA_DST(DATA_DST),
    .DATA_RDY(DATA_RDY),
    .DATA_READ(DATA_READ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] addr;
    int           slot;
    logic [31:0]  data;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setaddr(input int s, input logic [W-1:0] a);
    SLOT_ADDR[s*W +: W] = a;
  endtask

  task automatic push(input logic [W-1:0] a, input int s,
                      input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.slot = s;
    e.data = d;
    q.push_back(e);
  endtask

  // mode 0 normal, 1 FLUSH in DATA0, 2 drop CS in REQ, 3 stop in DATA1
  task automatic serve(input int mode);
    exp_t e;
    int n;
    n = 0;
    while (!SDRAM_REQ && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("req_seen", 32'(SDRAM_REQ), 32'd1);
    if (q.size() == 0) begin
      chk("queue_empty", 32'(q.size()), 32'd1);
      return;
    end
    e = q.pop_front();
    chk("req_addr", 32'(SDRAM_ADDR), 32'(e.addr));
    if (mode == 2) begin
      SLOT_CS[e.slot] = 1'b0;
      repeat (2) @(negedge CLK);
      chk("req_hold", {SDRAM_REQ, 10'd0, SDRAM_ADDR}, {1'b1, 10'd0, e.addr});
    end
    SDRAM_ACK = 1'b1;
    @(negedge CLK);
    SDRAM_ACK = 1'b0;
    chk("req_drop", 32'(SDRAM_REQ), 32'd0);
    if (mode == 1) begin
      FLUSH = 1'b1;
      @(negedge CLK);
      FLUSH = 1'b0;
    end
    DATA_DST  = 1'b1;
    DATA_READ = e.data[15:0];
    @(negedge CLK);
    DATA_DST  = 1'b0;
    DATA_READ = 16'hxxxx;
    if (mode == 3) return;
    DATA_RDY  = 1'b1;
    DATA_READ = e.data[31:16];
    @(negedge CLK);
    DATA_RDY  = 1'b0;
    DATA_READ = 16'h0;
    chk($sformatf("dout%0d", e.slot), SLOT_DOUT[e.slot*32 +: 32], e.data);
  endtask

  initial begin
    logic bad;
    RESET_N   = 1'b0;
    FLUSH     = 1'b0;
    SLOT_CS   = 4'b0;
    SLOT_ADDR = '0;
    SDRAM_ACK = 1'b0;
    DATA_DST  = 1'b0;
    DATA_RDY  = 1'b0;
    DATA_READ = 16'h0;
    repeat (2) @(negedge CLK);
    chk("rst_req", 32'(SDRAM_REQ), 32'd0);
    chk("rst_addr", 32'(SDRAM_ADDR), 32'd0);
    chk("rst_ok", 32'(SLOT_OK), 32'd0);
    chk("rst_dout", 32'(|SLOT_DOUT), 32'd0);

    // single miss and fill
    RESET_N = 1'b1;
    setaddr(0, 22'h000100);
    SLOT_CS = 4'b0001;
    push(22'h000100, 0, 32'hABCD1234);
    serve(0);
    chk("ok0_fill", 32'(SLOT_OK[0]), 32'd1);
    chk("req_idle", 32'(SDRAM_REQ), 32'd0);

    // steady hit, then address change
    bad = 1'b0;
    repeat (100) begin
      @(negedge CLK);
      if (SDRAM_REQ || !SLOT_OK[0]) bad = 1'b1;
    end
    chk("hold_hit", 32'(bad), 32'd0);
    setaddr(0, 22'h000102);
    #1;
    chk("ok0_drop", 32'(SLOT_OK[0]), 32'd0);
    push(22'h000102, 0, 32'h00020001);
    serve(0);
    chk("ok0_refill", 32'(SLOT_OK[0]), 32'd1);

    // four simultaneous misses from ptr=0
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    setaddr(0, 22'h000100);
    setaddr(1, 22'h000200);
    setaddr(2, 22'h000300);
    setaddr(3, 22'h000400);
    SLOT_CS = 4'b1111;
`ifdef TOAPLAN2_GFX_ARB_PRIO0_EN
    push(22'h000100, 0, 32'h10001000);
    push(22'h000200, 1, 32'h20002000);
    push(22'h000110, 0, 32'h11001100);
    push(22'h000300, 2, 32'h30003000);
    push(22'h000120, 0, 32'h12001200);
    push(22'h000400, 3, 32'h40004000);
    serve(0);
    serve(0);
    setaddr(0, 22'h000110);
    serve(0);
    serve(0);
    setaddr(0, 22'h000120);
    serve(0);
    serve(0);
`else
    push(22'h000100, 0, 32'h10001000);
    push(22'h000200, 1, 32'h20002000);
    push(22'h000300, 2, 32'h30003000);
    push(22'h000400, 3, 32'h40004000);
    repeat (4) serve(0);
`endif
    chk("ok_all", 32'(SLOT_OK), 32'hF);

    // FLUSH during DATA0 for slot 2
    SLOT_CS = 4'b0100;
    setaddr(2, 22'h000500);
    push(22'h000500, 2, 32'h5555AAAA);
    serve(1);
    chk("ok2_flushed", 32'(SLOT_OK[2]), 32'd0);
    push(22'h000500, 2, 32'h66667777);
    serve(0);
    chk("ok2_refill", 32'(SLOT_OK[2]), 32'd1);

    // CS dropped while REQ pending
    SLOT_CS = 4'b0010;
    setaddr(1, 22'h000600);
    push(22'h000600, 1, 32'h60606060);
    serve(2);
    chk("ok1_cs_low", 32'(SLOT_OK[1]), 32'd0);
    SLOT_CS[1] = 1'b1;
    #1;
    chk("ok1_reassert", 32'(SLOT_OK[1]), 32'd1);
    bad = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      if (SDRAM_REQ) bad = 1'b1;
    end
    chk("ok1_no_req", 32'(bad), 32'd0);

    // reset in DATA1
    SLOT_CS = 4'b0101;
    setaddr(0, 22'h000700);
    #1;
    chk("ok2_pre_rst", 32'(SLOT_OK[2]), 32'd1);
    push(22'h000700, 0, 32'h77007700);
    serve(3);
    RESET_N = 1'b0;
    #1;
    chk("rst1_req", 32'(SDRAM_REQ), 32'd0);
    chk("rst1_ok", 32'(SLOT_OK), 32'd0);
    chk("rst1_dout", 32'(|SLOT_DOUT), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    push(22'h000700, 0, 32'h71727374);
    push(22'h000500, 2, 32'h52525252);
    serve(0);
    serve(0);
    chk("ok_final", 32'(SLOT_OK), 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
